// File: rtl/latch_ctrl_pkg.sv
// Shared types and default sizing for the latch write arbiter.
// Holds the write-sequencer state encoding and the default parameter values.
// No ports; imported by latch_write_arbiter and rr_arbiter.
package latch_ctrl_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_OPEN_CYCLES = 1;

  // IDLE: arbitrate; SETUP: data settles before enable; OPEN: enable high;
  // HOLD: enable low, data still held, owner acknowledged.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } latch_state_e;

endpackage

// File: rtl/latch_write_arbiter_rr_arbiter.sv
// Round-robin selector: one-hot winner among req_i, searching upward from ptr_i.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when the winner is consumed.
// Ports: req_i request vector, ptr_i highest-priority index, gnt_o one-hot winner.
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int idx;
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Shares one D-latch bank among NUM_REQ requesters: round-robin pick, then
// SETUP/OPEN/HOLD enable sequencing; ack 2+OPEN_CYCLES cycles after the pick.
// Requests outside IDLE simply wait; data is frozen from pick until after HOLD.
// Ports: clk, rst_n (async low); req_i/data_i requesters; q_i latch readback;
// d_o/enable_o to latch; grant_o/ack_o/busy_o status; err_o readback mismatch.
// Option: define LATCH_WRITE_ARBITER_READBACK_EN to compare q_i with d_o in HOLD.
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0]         q_i,
  output logic [DATA_W-1:0]         d_o,
  output logic                      enable_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  latch_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]    d_q, d_d;
  logic                 en_q, en_d;

  logic [NUM_REQ-1:0]   win;
  logic [PTR_W-1:0]     win_idx;
  logic [DATA_W-1:0]    win_data;
  logic [PTR_W-1:0]     next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  // Winner's index and data slice; win is one-hot so at most one hit.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_idx  = PTR_W'(i);
        win_data = data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // The requester after the winner gets top priority next time.
  assign next_ptr = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);

  // Next-state and registered-output logic. d_d only moves on IDLE->SETUP,
  // which keeps the latch input stable across OPEN and HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    d_d     = d_q;
    en_d    = 1'b0;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = SETUP;
          grant_d = win;
          d_d     = win_data;
          ptr_d   = next_ptr;
        end
      end
      SETUP: begin
        state_d = OPEN;
        en_d    = 1'b1;
        cnt_d   = '0;
      end
      OPEN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
          ack_d   = grant_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          en_d  = 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      d_q     <= d_d;
      en_q    <= en_d;
    end
  end

`ifdef LATCH_WRITE_ARBITER_READBACK_EN
  logic err_q, err_d;

  // Latch output must equal what we wrote by HOLD; any miss is sticky.
  always_comb begin
    err_d = err_q;
    if ((state_q == HOLD) && (q_i != d_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_q_i;
  assign unused_q_i = ^q_i;
  assign err_o      = 1'b0;
`endif

  assign d_o      = d_q;
  assign enable_o = en_q;
  assign grant_o  = grant_q;
  assign ack_o    = ack_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: doc/latch_write_arbiter.md
LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one D-latch bank.
REQ-002 Parameter DATA_W, default 8: latch data width.
REQ-003 Parameter OPEN_CYCLES, default 1: cycles the latch enable is held high per write; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 req_i  input  NUM_REQ  level request per requester; held until its ack.
REQ-007 data_i  input  NUM_REQ*DATA_W  requester data; slice i = data_i[i*DATA_W +: DATA_W].
REQ-008 q_i  input  DATA_W  latch readback; used only with the macro in REQ-025.
REQ-009 d_o  output  DATA_W  data driven to the latch d input.
REQ-010 enable_o  output  1  latch enable.
REQ-011 grant_o  output  NUM_REQ  one-hot current owner; zero when idle.
REQ-012 ack_o  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 err_o  output  1  sticky readback-mismatch flag.

Function
REQ-015 FSM states: IDLE, SETUP, OPEN, HOLD; all outputs registered.
REQ-016 IDLE: on any req_i bit high, pick a winner round-robin, starting from the index after the last winner; register its data into d_o; set grant_o; go to SETUP.
REQ-017 SETUP lasts 1 cycle with enable_o=0 and d_o stable; then go to OPEN.
REQ-018 OPEN lasts exactly OPEN_CYCLES cycles with enable_o=1, counted by an internal counter; then go to HOLD.
REQ-019 HOLD lasts 1 cycle with enable_o=0 and d_o unchanged; ack_o[owner]=1 for that cycle only; then go to IDLE and clear grant_o.
REQ-020 d_o changes only on the IDLE->SETUP transition; it SHALL never change while enable_o=1 or in HOLD.
REQ-021 Per-write latency: IDLE decision to ack is 2+OPEN_CYCLES cycles; at least 1 IDLE cycle separates writes.
REQ-022 The owner deasserting req_i mid-transfer SHALL NOT abort the write; ack still pulses.
REQ-023 Requests arriving outside IDLE wait; the round-robin pointer advances only on a grant.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, d_o=0, enable_o=0, grant_o=0, ack_o=0, busy_o=0, err_o=0, and the round-robin pointer to give req 0 top priority; this applies in any state, including mid-OPEN.

Configuration
REQ-025 Macro LATCH_WRITE_ARBITER_READBACK_EN defined: in HOLD, compare q_i to d_o; on mismatch, set err_o and hold it until reset.
REQ-026 Macro undefined: q_i is ignored and err_o is tied 0; all other behaviour is identical.

Structure
REQ-027 Package latch_ctrl_pkg SHALL hold the FSM state typedef (IDLE, SETUP, OPEN, HOLD) and the default width constants.
REQ-028 Round-robin selection SHALL be the sub-module rr_arbiter: inputs are the request vector and pointer; output is the one-hot winner.

Verification (NUM_REQ=4, DATA_W=8, OPEN_CYCLES=2)
REQ-029 After reset, req_i=0010 with slice1=0xA5 -> grant_o=0010, then 1 SETUP cycle, 2 cycles of enable_o=1, then ack_o=0010 for 1 cycle; d_o=0xA5 throughout; busy_o high for 4 cycles.
REQ-030 req_i=1111 held until each ack -> acks in order 0001, 0010, 0100, 1000; with requests re-raised, the next order is again 0001, 0010, 0100, 1000.
REQ-031 rst_n low during the 2nd OPEN cycle -> enable_o=0 in the same cycle and all outputs 0; after release, req_i=1100 -> grant_o=0100.
REQ-032 Owner drops req_i during SETUP -> enable still high for 2 cycles; ack pulses in HOLD; the next arbitration excludes it.
REQ-033 Macro defined, d_o=0x3C, q_i stuck 0x00 -> err_o=1 from the cycle after HOLD until reset; macro undefined -> err_o stays 0.
REQ-034 In every scenario, check that d_o never changes while enable_o=1 and that grant_o is one-hot or zero.
